fib_mem: RTL and testbench
==========================

# fib_mem

Memo-table responder for the Fibonacci stack controller. It owns the table RAM, decodes the controller's registered request stream (`wren`, `address`, `stage`) and performs the corresponding work:

- seed writes;
- operand reads;
- pipelined sum write-back;
- result readout.

It is the memory/datapath end of the controller's request interface, with sticky overflow and protocol-error flags for status.

## Interface
- `ADDR_W`, default 12: table address width; the table has 2^ADDR_W entries.
- `DATA_W`, default 12: entry and result width.
- `CLK` in 1: the only clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `wren` in 1: request write qualifier from the controller.
- `address` in ADDR_W: request address.
- `stage` in 2: request opcode, decoded together with `wren`.
- `result` out DATA_W: table value from the most recent result read.
- `result_valid` out 1: high while `result` reflects a result read sampled 2 cycles earlier.
- `hi_addr` out ADDR_W: highest address written since reset.
- `ovf` out 1: sticky; set when a sum exceeded DATA_W bits.
- `err` out 1: sticky; set on an illegal request.

## Operation
The request is sampled on every rising edge. Decode of {`stage`, `wren`}:
- 00/0, idle: no action.
- 00/1, seed write: `mem[address]` <= (`address`==0) ? 0 : 1.
- 01/0, operand A read: `a_reg` <= `mem[address]`.
- 10/0, operand B read: `b_reg` <= `mem[address]`.
- 11/1, sum write: latched into the pending-write register (`pend_v`, `pend_addr`). The following cycle `mem[pend_addr]` <= `a_reg` + `b_reg`.
- 11/0, result read: `result` <= `mem[address]`.
- 01/1 or 10/1: illegal. No memory or register change; `err` <= 1.

Arithmetic and status:
- The sum is computed at DATA_W+1 bits. The low DATA_W bits are stored. If bit DATA_W is 1, `ovf` <= 1; `ovf` is never cleared except by reset.
- `hi_addr` <= max(`hi_addr`, write address) on every committed seed or sum write.

Forwarding (write-first): any read whose address equals a write committed in the same or the previous cycle returns the newly written value. This includes operand reads and result reads, and covers a read of `pend_addr` issued right after the sum-write request.

Memory contents are not cleared by reset; the controller reseeds the table after reset.

## Timing
- Operand reads: a read sampled at edge t loads `a_reg`/`b_reg` at edge t+1. A B read immediately followed by a sum-write request is legal without stalls: the sum is committed at edge t+2 and uses the loaded `b_reg`.
- Seed writes commit at the sampling edge. Sum writes commit one edge after sampling.
- Result reads: a read sampled at edge r gives `result`/`result_valid` at edge r+2.
  - `result_valid` stays high for as long as result reads keep arriving.
  - It drops 2 edges after the first non-result request.
  - A held stage 11/0 with a constant address yields a steady `result`.
- Reset values: `result`=0, `result_valid`=0, `hi_addr`=0, `ovf`=0, `err`=0, `a_reg`=`b_reg`=0, `pend_v`=0.
- Reset mid-operation: a pending sum write and any in-flight result read are discarded, with no memory write.
- Back-to-back sum-write requests: each one commits in order, one per cycle.
- `address` wrap: no special handling. `hi_addr` saturates naturally at 2^ADDR_W-1.

## Test plan
- Seed and compute: seed addresses 0 and 1. Then loop for n=2..10: A read n-2, B read n-1, sum write n. Result read 10 -> `result`=55 at r+2; `hi_addr`=10; `ovf`=0.
- Overflow: extend the loop to n=19 -> `mem[19]`=85 (4181 mod 4096); `ovf` goes to 1 at the commit edge and stays 1 through later writes.
- Forwarding: sum write to 5, then a result read of 5 on the very next cycle -> returns the new sum, not the stale contents.
- Illegal request: {`stage`=01, `wren`=1} at address 3 -> `err`=1, `mem[3]` unchanged, and no change to `a_reg`, `b_reg` or `result`.
- Reset during pending write: assert `reset` on the cycle after a sum-write request to 7 -> `mem[7]` keeps its prior value, and all outputs read 0 the next cycle.
- Held result: keep 11/0 at address 10 for 20 cycles -> `result_valid` stays high and `result`=55 throughout; `result_valid` falls 2 edges after the request changes to idle.

Source files
------------

// File: rtl/fib_mem_if.sv
// Request/response bundle between the Fibonacci stack controller and the
// fib_mem memo-table responder.
//
// Handshake: there is no valid/ready pair. The controller presents one
// registered request {stage, wren, address} every cycle; {00, 0} is the idle
// encoding. The responder accepts every request on the rising edge and never
// back-pressures, so each non-idle request is a transfer by definition.
// result_valid marks the cycles in which result reflects a result read.
interface fib_mem_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 12
);
  // Request side (driven by the controller)
  logic              wren;
  logic [ADDR_W-1:0] address;
  logic [1:0]        stage;

  // Response and status side (driven by fib_mem)
  logic [DATA_W-1:0] result;
  logic              result_valid;
  logic [ADDR_W-1:0] hi_addr;
  logic              ovf;
  logic              err;

  // Observation of internal operand/pending state for checkers
  logic [DATA_W-1:0] dbg_a_reg;
  logic [DATA_W-1:0] dbg_b_reg;
  logic              dbg_pend_v;

  modport master (
    output wren, address, stage,
    input  result, result_valid, hi_addr, ovf, err,
    input  dbg_a_reg, dbg_b_reg, dbg_pend_v
  );

  modport slave (
    input  wren, address, stage,
    output result, result_valid, hi_addr, ovf, err,
    output dbg_a_reg, dbg_b_reg, dbg_pend_v
  );
endinterface

// File: rtl/fib_mem.sv
// fib_mem: memo-table RAM and datapath for the Fibonacci stack controller.
// Decodes the registered request stream into seed writes, operand reads,
// a one-cycle-deferred sum write-back and a two-cycle result readout, and
// keeps sticky overflow / protocol-error status plus the highest written
// address.
module fib_mem #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 12
) (
  input  logic      CLK,
  input  logic      reset,
  fib_mem_if.slave  bus
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [2:0] {
    OP_IDLE,
    OP_SEED,
    OP_RD_A,
    OP_RD_B,
    OP_SUM,
    OP_RD_RES,
    OP_ILLEGAL
  } op_e;

  // Table storage; intentionally not cleared by reset (controller reseeds).
  logic [DATA_W-1:0] r_mem [DEPTH];

  // Read pipeline: a request sampled at edge t is performed at edge t+1.
  logic              r_rd_a_v;
  logic              r_rd_b_v;
  logic              r_rd_res_v;
  logic [ADDR_W-1:0] r_rd_addr;

  // Pending sum write: latched at the request edge, committed one edge later.
  logic              r_pend_v;
  logic [ADDR_W-1:0] r_pend_addr;

  // Operand registers feeding the adder.
  logic [DATA_W-1:0] r_a_reg;
  logic [DATA_W-1:0] r_b_reg;

  // Result path: read data captured at r+1, presented at r+2.
  logic              r_res_v;
  logic [DATA_W-1:0] r_res_data;
  logic [DATA_W-1:0] r_result;
  logic              r_result_valid;

  // Status.
  logic [ADDR_W-1:0] r_hi_addr;
  logic              r_ovf;
  logic              r_err;

  op_e               w_op;
  logic              w_seed_we;
  logic [DATA_W-1:0] w_seed_data;
  logic              w_sum_we;
  logic [DATA_W:0]   w_sum;
  logic [DATA_W-1:0] w_rd_data;
  logic [ADDR_W-1:0] w_hi_next;

  // Decode {stage, wren} into a single operation code.
  always_comb begin
    w_op = OP_IDLE;
    case ({bus.stage, bus.wren})
      3'b000:  w_op = OP_IDLE;
      3'b001:  w_op = OP_SEED;
      3'b010:  w_op = OP_RD_A;
      3'b100:  w_op = OP_RD_B;
      3'b111:  w_op = OP_SUM;
      3'b110:  w_op = OP_RD_RES;
      default: w_op = OP_ILLEGAL;
    endcase
  end

  // Seeds commit at their own sampling edge; reset suppresses them.
  assign w_seed_we   = (w_op == OP_SEED) && !reset;
  assign w_seed_data = (bus.address == '0) ? '0 : DATA_W'(1);

  // The sum carries one extra bit so overflow can be detected.
  assign w_sum    = {1'b0, r_a_reg} + {1'b0, r_b_reg};
  assign w_sum_we = r_pend_v && !reset;

  // Write-first read port. A read is performed one edge after it is sampled,
  // so a sum committed at the previous edge is already in the array and a
  // sum can never commit on the same edge as a read of it. Only a seed
  // sampled on the read edge needs forwarding.
  assign w_rd_data = (w_seed_we && (bus.address == r_rd_addr)) ? w_seed_data
                                                               : r_mem[r_rd_addr];

  // Highest written address across both write sources committing this edge.
  always_comb begin
    w_hi_next = r_hi_addr;
    if (w_sum_we && (r_pend_addr > w_hi_next)) begin
      w_hi_next = r_pend_addr;
    end
    if (w_seed_we && (bus.address > w_hi_next)) begin
      w_hi_next = bus.address;
    end
  end

  // Table writes. A deferred sum and a new seed may land on the same edge;
  // the seed is the later request, so it is applied last and wins on a
  // shared address.
  always_ff @(posedge CLK) begin
    if (w_sum_we) begin
      r_mem[r_pend_addr] <= w_sum[DATA_W-1:0];
    end
    if (w_seed_we) begin
      r_mem[bus.address] <= w_seed_data;
    end
  end

  // Request pipeline, operand/result registers and sticky status.
  always_ff @(posedge CLK) begin
    if (reset) begin
      r_rd_a_v       <= 1'b0;
      r_rd_b_v       <= 1'b0;
      r_rd_res_v     <= 1'b0;
      r_rd_addr      <= '0;
      r_pend_v       <= 1'b0;
      r_pend_addr    <= '0;
      r_a_reg        <= '0;
      r_b_reg        <= '0;
      r_res_v        <= 1'b0;
      r_res_data     <= '0;
      r_result       <= '0;
      r_result_valid <= 1'b0;
      r_hi_addr      <= '0;
      r_ovf          <= 1'b0;
      r_err          <= 1'b0;
    end else begin
      r_rd_a_v    <= (w_op == OP_RD_A);
      r_rd_b_v    <= (w_op == OP_RD_B);
      r_rd_res_v  <= (w_op == OP_RD_RES);
      r_rd_addr   <= bus.address;
      r_pend_v    <= (w_op == OP_SUM);
      r_pend_addr <= bus.address;

      if (r_rd_a_v) begin
        r_a_reg <= w_rd_data;
      end
      if (r_rd_b_v) begin
        r_b_reg <= w_rd_data;
      end

      r_res_v <= r_rd_res_v;
      if (r_rd_res_v) begin
        r_res_data <= w_rd_data;
      end
      r_result_valid <= r_res_v;
      if (r_res_v) begin
        r_result <= r_res_data;
      end

      r_hi_addr <= w_hi_next;
      if (w_sum_we && w_sum[DATA_W]) begin
        r_ovf <= 1'b1;
      end
      if (w_op == OP_ILLEGAL) begin
        r_err <= 1'b1;
      end
    end
  end

  assign bus.result       = r_result;
  assign bus.result_valid = r_result_valid;
  assign bus.hi_addr      = r_hi_addr;
  assign bus.ovf          = r_ovf;
  assign bus.err          = r_err;
  assign bus.dbg_a_reg    = r_a_reg;
  assign bus.dbg_b_reg    = r_b_reg;
  assign bus.dbg_pend_v   = r_pend_v;

endmodule

// File: tb/tb_fib_mem.sv
// Testbench for fib_mem: directed scenarios from the Fibonacci use case plus
// a randomized run against a cycle-level reference model of the request
// rules (writes commit, reads land one edge later, results two edges later).
module tb_fib_mem;

  localparam int AW = 12;
  localparam int DW = 12;

  localparam int K_IDLE = 0;
  localparam int K_SEED = 1;
  localparam int K_A    = 2;
  localparam int K_B    = 3;
  localparam int K_SUM  = 4;
  localparam int K_RES  = 5;
  localparam int K_ILL  = 6;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fib_mem_if #(.ADDR_W(AW), .DATA_W(DW)) bus();
  fib_mem #(.ADDR_W(AW), .DATA_W(DW)) dut (.CLK(clk), .reset(rst), .bus(bus));

  int n_vec = 0;
  int n_err = 0;

  // ---------------- reference model ----------------
  logic [DW-1:0] m_mem [4096];
  logic [DW-1:0] m_a = '0, m_b = '0, m_result = '0, m_resq_d = '0;
  logic          m_result_valid = 1'b0, m_resq_v = 1'b0;
  logic          m_ovf = 1'b0, m_err = 1'b0, m_pend_v = 1'b0;
  logic [AW-1:0] m_hi = '0;
  int            m_prev = K_IDLE;
  logic [AW-1:0] m_prev_addr = '0;

  function automatic int kind(input logic [1:0] st, input logic wr);
    case ({st, wr})
      3'b000:  return K_IDLE;
      3'b001:  return K_SEED;
      3'b010:  return K_A;
      3'b100:  return K_B;
      3'b111:  return K_SUM;
      3'b110:  return K_RES;
      default: return K_ILL;
    endcase
  endfunction

  // Advance the model by one rising edge with the request sampled there.
  function automatic void model_edge(input logic rs, input logic [1:0] st,
                                     input logic wr, input logic [AW-1:0] ad);
    int cur;
    int s;
    cur = kind(st, wr);
    if (rs) begin
      m_a = '0; m_b = '0; m_result = '0; m_result_valid = 1'b0;
      m_resq_v = 1'b0; m_hi = '0; m_ovf = 1'b0; m_err = 1'b0;
      m_pend_v = 1'b0; m_prev = K_IDLE;
      return;
    end
    // Writes landing on this edge: last cycle's sum, then this cycle's seed.
    if (m_prev == K_SUM) begin
      s = int'(m_a) + int'(m_b);
      m_mem[m_prev_addr] = DW'(s % (1 << DW));
      if (s >= (1 << DW)) m_ovf = 1'b1;
      if (m_prev_addr > m_hi) m_hi = m_prev_addr;
    end
    if (cur == K_SEED) begin
      m_mem[ad] = (ad == 0) ? DW'(0) : DW'(1);
      if (ad > m_hi) m_hi = ad;
    end
    if (cur == K_ILL) m_err = 1'b1;
    // Result presented two edges after its read; reads see post-write table.
    m_result_valid = m_resq_v;
    if (m_resq_v) m_result = m_resq_d;
    m_resq_v = (m_prev == K_RES);
    if (m_prev == K_RES) m_resq_d = m_mem[m_prev_addr];
    if (m_prev == K_A) m_a = m_mem[m_prev_addr];
    if (m_prev == K_B) m_b = m_mem[m_prev_addr];
    m_pend_v = (cur == K_SUM);
    m_prev = cur;
    m_prev_addr = ad;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step(input logic [1:0] st, input logic wr,
                      input logic [AW-1:0] ad, input logic rs);
    rst = rs;
    bus.stage = st;
    bus.wren = wr;
    bus.address = ad;
    @(posedge clk);
    model_edge(rs, st, wr, ad);
    #1;
  endtask

  task automatic idle();                   step(2'b00, 1'b0, '0, 1'b0); endtask
  task automatic seed(input int a);        step(2'b00, 1'b1, AW'(a), 1'b0); endtask
  task automatic rd_a(input int a);        step(2'b01, 1'b0, AW'(a), 1'b0); endtask
  task automatic rd_b(input int a);        step(2'b10, 1'b0, AW'(a), 1'b0); endtask
  task automatic sum_wr(input int a);      step(2'b11, 1'b1, AW'(a), 1'b0); endtask
  task automatic rd_res(input int a);      step(2'b11, 1'b0, AW'(a), 1'b0); endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    step(2'b00, 1'b0, '0, 1'b1);
    step(2'b00, 1'b0, '0, 1'b1);
    n_vec++; if (bus.result !== '0) begin n_err++; $display("FAIL reset_result got=%0d exp=0", bus.result); end
    n_vec++; if (bus.result_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%0b exp=0", bus.result_valid); end
    n_vec++; if (bus.hi_addr !== '0) begin n_err++; $display("FAIL reset_hi got=%0d exp=0", bus.hi_addr); end
    n_vec++; if (bus.ovf !== 1'b0) begin n_err++; $display("FAIL reset_ovf got=%0b exp=0", bus.ovf); end
    n_vec++; if (bus.err !== 1'b0) begin n_err++; $display("FAIL reset_err got=%0b exp=0", bus.err); end
    n_vec++; if (bus.dbg_a_reg !== '0 || bus.dbg_b_reg !== '0) begin n_err++; $display("FAIL reset_ab got=%0d/%0d exp=0/0", bus.dbg_a_reg, bus.dbg_b_reg); end
    n_vec++; if (bus.dbg_pend_v !== 1'b0) begin n_err++; $display("FAIL reset_pend got=%0b exp=0", bus.dbg_pend_v); end
  endtask

  task automatic test_seed_compute();
    seed(0);
    seed(1);
    for (int n = 2; n <= 10; n++) begin
      rd_a(n - 2);
      rd_b(n - 1);
      sum_wr(n);
    end
    rd_res(10);
    idle();
    n_vec++; if (bus.result_valid !== 1'b0) begin n_err++; $display("FAIL fib10_early_valid got=%0b exp=0", bus.result_valid); end
    idle();
    n_vec++; if (bus.result !== 12'd55 || bus.result_valid !== 1'b1) begin n_err++; $display("FAIL fib10_result got=%0d/%0b exp=55/1", bus.result, bus.result_valid); end
    n_vec++; if (bus.hi_addr !== 12'd10) begin n_err++; $display("FAIL fib10_hi got=%0d exp=10", bus.hi_addr); end
    n_vec++; if (bus.ovf !== 1'b0) begin n_err++; $display("FAIL fib10_ovf got=%0b exp=0", bus.ovf); end
    n_vec++; if (bus.dbg_a_reg !== 12'd21 || bus.dbg_b_reg !== 12'd34) begin n_err++; $display("FAIL fib10_ab got=%0d/%0d exp=21/34", bus.dbg_a_reg, bus.dbg_b_reg); end
  endtask

  task automatic test_overflow();
    for (int n = 11; n <= 19; n++) begin
      rd_a(n - 2);
      rd_b(n - 1);
      sum_wr(n);
    end
    n_vec++; if (bus.ovf !== 1'b0) begin n_err++; $display("FAIL ovf_before_commit got=%0b exp=0", bus.ovf); end
    idle();
    n_vec++; if (bus.ovf !== 1'b1) begin n_err++; $display("FAIL ovf_at_commit got=%0b exp=1", bus.ovf); end
    rd_res(19);
    idle();
    idle();
    n_vec++; if (bus.result !== 12'd85) begin n_err++; $display("FAIL fib19_wrapped got=%0d exp=85", bus.result); end
    seed(25);
    idle();
    n_vec++; if (bus.ovf !== 1'b1 || bus.hi_addr !== 12'd25) begin n_err++; $display("FAIL ovf_sticky got=%0b hi=%0d exp=1 hi=25", bus.ovf, bus.hi_addr); end
  endtask

  task automatic test_forwarding();
    rd_a(9);
    rd_b(10);
    sum_wr(5);
    rd_res(5);
    idle();
    idle();
    n_vec++; if (bus.result !== 12'd89) begin n_err++; $display("FAIL fwd_sum_then_read got=%0d exp=89", bus.result); end
    rd_a(12);
    seed(12);
    n_vec++; if (bus.dbg_a_reg !== 12'd1) begin n_err++; $display("FAIL fwd_seed_operand got=%0d exp=1", bus.dbg_a_reg); end
    rd_res(13);
    seed(13);
    idle();
    n_vec++; if (bus.result !== 12'd1) begin n_err++; $display("FAIL fwd_seed_result got=%0d exp=1", bus.result); end
  endtask

  task automatic test_illegal();
    n_vec++; if (bus.err !== 1'b0) begin n_err++; $display("FAIL err_before got=%0b exp=0", bus.err); end
    step(2'b01, 1'b1, 12'd3, 1'b0);
    n_vec++; if (bus.err !== 1'b1) begin n_err++; $display("FAIL err_set got=%0b exp=1", bus.err); end
    n_vec++; if (bus.dbg_a_reg !== m_a || bus.dbg_b_reg !== m_b || bus.result !== m_result) begin n_err++; $display("FAIL illegal_regs got=%0d/%0d/%0d exp=%0d/%0d/%0d", bus.dbg_a_reg, bus.dbg_b_reg, bus.result, m_a, m_b, m_result); end
    step(2'b10, 1'b1, 12'd3, 1'b0);
    n_vec++; if (bus.err !== 1'b1 || bus.hi_addr !== m_hi) begin n_err++; $display("FAIL err_sticky got=%0b hi=%0d exp=1 hi=%0d", bus.err, bus.hi_addr, m_hi); end
    rd_res(3);
    idle();
    idle();
    n_vec++; if (bus.result !== 12'd2) begin n_err++; $display("FAIL illegal_mem3 got=%0d exp=2", bus.result); end
  endtask

  task automatic test_held_result();
    for (int i = 0; i < 20; i++) begin
      rd_res(10);
      if (i >= 2) begin
        n_vec++;
        if (bus.result_valid !== 1'b1 || bus.result !== 12'd55) begin
          n_err++; $display("FAIL held_result cyc=%0d got=%0d/%0b exp=55/1", i, bus.result, bus.result_valid);
        end
      end
    end
    idle();
    n_vec++; if (bus.result_valid !== 1'b1) begin n_err++; $display("FAIL held_tail1 got=%0b exp=1", bus.result_valid); end
    idle();
    n_vec++; if (bus.result_valid !== 1'b1) begin n_err++; $display("FAIL held_tail2 got=%0b exp=1", bus.result_valid); end
    idle();
    n_vec++; if (bus.result_valid !== 1'b0 || bus.result !== 12'd55) begin n_err++; $display("FAIL held_drop got=%0b/%0d exp=0/55", bus.result_valid, bus.result); end
  endtask

  task automatic test_back_to_back();
    rd_a(4);
    rd_b(10);
    sum_wr(20);
    sum_wr(21);
    sum_wr(22);
    n_vec++; if (bus.dbg_pend_v !== 1'b1) begin n_err++; $display("FAIL b2b_pend got=%0b exp=1", bus.dbg_pend_v); end
    rd_res(20);
    rd_res(21);
    for (int i = 0; i < 3; i++) begin
      if (i == 0) rd_res(22); else idle();
      n_vec++;
      if (bus.result !== 12'd58 || bus.result_valid !== 1'b1) begin
        n_err++; $display("FAIL b2b_result idx=%0d got=%0d/%0b exp=58/1", i, bus.result, bus.result_valid);
      end
    end
    n_vec++; if (bus.hi_addr !== m_hi) begin n_err++; $display("FAIL b2b_hi got=%0d exp=%0d", bus.hi_addr, m_hi); end
  endtask

  task automatic test_reset_pending();
    rd_a(2);
    rd_b(3);
    sum_wr(7);
    step(2'b00, 1'b0, '0, 1'b1);
    n_vec++;
    if (bus.result !== '0 || bus.result_valid !== 1'b0 || bus.hi_addr !== '0 || bus.ovf !== 1'b0 ||
        bus.err !== 1'b0 || bus.dbg_a_reg !== '0 || bus.dbg_b_reg !== '0 || bus.dbg_pend_v !== 1'b0) begin
      n_err++; $display("FAIL rst_pend_outputs got=%0d/%0b/%0d/%0b/%0b/%0d/%0d/%0b exp=all 0", bus.result, bus.result_valid,
                        bus.hi_addr, bus.ovf, bus.err, bus.dbg_a_reg, bus.dbg_b_reg, bus.dbg_pend_v);
    end
    rd_res(7);
    idle();
    idle();
    n_vec++; if (bus.result !== 12'd13 || bus.result_valid !== 1'b1) begin n_err++; $display("FAIL rst_pend_mem7 got=%0d/%0b exp=13/1", bus.result, bus.result_valid); end
  endtask

  task automatic test_random();
    logic [51:0] obs;
    logic [51:0] exp;
    int r;
    for (int a = 0; a < 32; a++) seed(a);
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 99);
      if (r < 3)       step(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)), 1'b1);
      else if (r < 8)  step((r < 6) ? 2'b01 : 2'b10, 1'b1, AW'($urandom_range(0, 31)), 1'b0);
      else if (r < 20) seed($urandom_range(0, 31));
      else if (r < 38) rd_a($urandom_range(0, 31));
      else if (r < 56) rd_b($urandom_range(0, 31));
      else if (r < 72) sum_wr($urandom_range(0, 31));
      else if (r < 92) rd_res($urandom_range(0, 31));
      else             idle();
      obs = {bus.result, bus.result_valid, bus.hi_addr, bus.ovf, bus.err, bus.dbg_a_reg, bus.dbg_b_reg, bus.dbg_pend_v};
      exp = {m_result, m_result_valid, m_hi, m_ovf, m_err, m_a, m_b, m_pend_v};
      n_vec++;
      if (obs !== exp) begin
        n_err++; $display("FAIL random cyc=%0d got=%h exp=%h", i, obs, exp);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    bus.stage = 2'b00;
    bus.wren = 1'b0;
    bus.address = '0;
    test_reset();
    test_seed_compute();
    test_overflow();
    test_forwarding();
    test_illegal();
    test_held_result();
    test_back_to_back();
    test_reset_pending();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
